bht_predictor: RTL and testbench

- Branch history table for the CVA6 frontend, sized from the core config (BHTEntries = 128, XLEN = 32, RVC enabled).
- Holds one 2-bit saturating counter per entry. Answers one direction lookup per cycle with a registered result.
- Accepts one resolved-branch update per cycle from the controller/commit path.
- The storage array has no reset. Reset and flush each trigger an FSM sweep that clears one entry per cycle.

---
 rtl/bht_predictor_pkg.sv | 38 +++
 rtl/bht_predictor_if.sv | 46 ++++
 rtl/bht_predictor_cnt_ram.sv | 45 ++++
 rtl/bht_predictor.sv | 149 ++++++++++++++
 tb/tb_bht_predictor.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/bht_predictor_pkg.sv
// Shared BHT types, constants and PC-to-index helper for the frontend predictor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bht_predictor_pkg;

  // PC width of the integrated core; the update struct is sized from it.
  localparam int unsigned BHT_XLEN = 32;

  // 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  typedef logic [1:0] bht_cnt_t;

  // Value written by the clearing sweep (weak not-taken).
  localparam bht_cnt_t BHT_CNT_CLEAR = 2'b01;

  // Predictor control states.
  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } bht_state_e;

  // Resolved-branch update as it travels from the controller/commit path.
  typedef struct packed {
    logic                valid;
    logic [BHT_XLEN-1:0] pc;
    logic                taken;
  } bht_update_t;

  // Table index: drop the instruction-alignment bits (1 with RVC, 2 without)
  // and keep log2(n) bits. Higher PC bits alias on purpose.
  function automatic int unsigned bht_index(input logic [63:0] pc,
                                            input bit          rvc,
                                            input int unsigned n);
    int unsigned ofs;
    ofs = rvc ? 32'd1 : 32'd2;
    return 32'(pc >> ofs) & (n - 32'd1);
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Lookup / update / flush signal bundle between the frontend and the BHT.
// Latency: n/a (wires only).
// Backpressure: none; the predictor accepts every request, busy_o is informational.
interface bht_predictor_if
  import bht_predictor_pkg::*;
#(
  parameter int unsigned XLEN = BHT_XLEN
);

  logic            flush_bp_i;
  logic            lookup_valid_i;
  logic [XLEN-1:0] lookup_pc_i;
  logic            pred_valid_o;
  logic            pred_taken_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic            busy_o;

  // Frontend / controller side.
  modport master (
    output flush_bp_i,
    output lookup_valid_i,
    output lookup_pc_i,
    input  pred_valid_o,
    input  pred_taken_o,
    output upd_valid_i,
    output upd_pc_i,
    output upd_taken_i,
    input  busy_o
  );

  // Predictor side.
  modport slave (
    input  flush_bp_i,
    input  lookup_valid_i,
    input  lookup_pc_i,
    output pred_valid_o,
    output pred_taken_o,
    input  upd_valid_i,
    input  upd_pc_i,
    input  upd_taken_i,
    output busy_o
  );

endinterface

// File: rtl/bht_predictor_cnt_ram.sv
// NR_ENTRIES x 2-bit counter array: one registered lookup read, one write port with current-value tap.
// Latency: lookup data valid one cycle after i_rd_en; writes visible to reads from the next cycle.
// Backpressure: none; the read register holds its value when i_rd_en is low.
module bht_predictor_cnt_ram
  import bht_predictor_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 128,
  parameter int unsigned IDX_W      = $clog2(NR_ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bht_cnt_t         o_rd_dat,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  bht_cnt_t         i_wr_dat,
  output bht_cnt_t         o_wr_old
);

  // Storage is deliberately left unreset; the predictor sweeps it clear.
  bht_cnt_t r_mem [NR_ENTRIES];
  bht_cnt_t r_rd_dat;

  // Counter storage write; no reset so it can map onto SRAM/LUTRAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_dat;
    end
  end

  // Registered lookup read; sees the array before this cycle's write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_dat <= '0;
    end else if (i_rd_en) begin
      r_rd_dat <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_dat = r_rd_dat;
  // Current value at the write address, feeding the saturating increment.
  assign o_wr_old = r_mem[i_wr_idx];

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: 2-bit saturating counters, lookup + resolved-branch update each cycle.
// Latency: prediction one cycle after lookup; update visible to lookups from the next cycle.
// Backpressure: none; lookups/updates during a clearing sweep or flush cycle are dropped, busy_o flags the sweep.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 128,
  parameter int unsigned XLEN       = BHT_XLEN,
  parameter int unsigned RVC        = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  bht_predictor_if.slave bus
);

  localparam int unsigned IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  bht_state_e       r_state;
  bht_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx;
  logic [IDX_W-1:0] w_sweep_idx_nxt;
  logic             r_pred_valid;

  bht_update_t      w_upd;
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_lk_en;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  bht_cnt_t         w_wr_dat;
  bht_cnt_t         w_wr_old;
  bht_cnt_t         w_upd_new;
  bht_cnt_t         w_rd_dat;
  logic             w_busy;

  assign w_upd.valid = bus.upd_valid_i;
  assign w_upd.pc    = BHT_XLEN'(bus.upd_pc_i);
  assign w_upd.taken = bus.upd_taken_i;

  assign w_lk_idx  = IDX_W'(bht_index(64'(bus.lookup_pc_i), RVC != 0, NR_ENTRIES));
  assign w_upd_idx = IDX_W'(bht_index(64'(w_upd.pc), RVC != 0, NR_ENTRIES));

  // State register: reset (and mid-sweep reset) always restarts the sweep at entry 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_idx_nxt;
    end
  end

  // Next state: sweep one entry per cycle, leave after the last; flush restarts from 0.
  always_comb begin
    w_state_nxt     = r_state;
    w_sweep_idx_nxt = r_sweep_idx;
    case (r_state)
      ST_SWEEP: begin
        if (bus.flush_bp_i) begin
          w_sweep_idx_nxt = '0;
        end else if (r_sweep_idx == LAST_IDX) begin
          w_state_nxt     = ST_RUN;
          w_sweep_idx_nxt = '0;
        end else begin
          w_sweep_idx_nxt = r_sweep_idx + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.flush_bp_i) begin
          w_state_nxt     = ST_SWEEP;
          w_sweep_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt     = ST_SWEEP;
        w_sweep_idx_nxt = '0;
      end
    endcase
  end

  // Outputs: sweep owns the write port; in RUN it carries updates, and a flush kills both ports.
  always_comb begin
    w_busy   = 1'b0;
    w_lk_en  = 1'b0;
    w_wr_en  = 1'b0;
    w_wr_idx = w_upd_idx;
    w_wr_dat = w_upd_new;
    case (r_state)
      ST_SWEEP: begin
        w_busy   = 1'b1;
        w_wr_en  = 1'b1;
        w_wr_idx = r_sweep_idx;
        w_wr_dat = BHT_CNT_CLEAR;
      end
      ST_RUN: begin
        w_lk_en = rst_ni & bus.lookup_valid_i & ~bus.flush_bp_i;
        w_wr_en = rst_ni & w_upd.valid & ~bus.flush_bp_i;
      end
      default: begin
        w_busy = 1'b1;
      end
    endcase
  end

  // Saturating step of the counter currently stored at the update index.
  always_comb begin
    w_upd_new = w_wr_old;
    if (w_upd.taken) begin
      if (w_wr_old != 2'b11) begin
        w_upd_new = w_wr_old + 2'b01;
      end
    end else begin
      if (w_wr_old != 2'b00) begin
        w_upd_new = w_wr_old - 2'b01;
      end
    end
  end

  // Prediction valid tracks the accepted lookup by one cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pred_valid <= 1'b0;
    end else begin
      r_pred_valid <= w_lk_en;
    end
  end

  bht_predictor_cnt_ram #(
    .NR_ENTRIES (NR_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_cnt_ram (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_rd_en  (w_lk_en),
    .i_rd_idx (w_lk_idx),
    .o_rd_dat (w_rd_dat),
    .i_wr_en  (w_wr_en),
    .i_wr_idx (w_wr_idx),
    .i_wr_dat (w_wr_dat),
    .o_wr_old (w_wr_old)
  );

  assign bus.pred_valid_o = r_pred_valid;
  assign bus.pred_taken_o = w_rd_dat[1];
  assign bus.busy_o       = w_busy;

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor with a counter-table model and prediction scoreboard.
// Latency: checks every cycle one clock after the inputs are applied.
// Backpressure: n/a.
module tb_bht_predictor;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  bht_predictor_if #(.XLEN(32)) bus();

  bht_predictor #(
    .NR_ENTRIES (128),
    .XLEN       (32),
    .RVC        (1)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  int       n_vec = 0;
  int       n_err = 0;
  bit [1:0] m_tab [128];
  int       m_left = 128;
  bit       m_last = 1'b0;
  bit       q_exp [$];

  localparam logic [31:0] PC_A  = 32'h8000_0010;
  localparam logic [31:0] PC_AL = 32'h8000_0110;
  localparam logic [31:0] PC_B  = 32'h8000_0012;

  // One clock: drive inputs, update the model, then check busy/valid/taken.
  task automatic step(input bit rst, input bit fl, input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input bit ut, input string tag);
    bit       ev;
    bit [6:0] li;
    bit [6:0] ui;
    rst_ni             = rst;
    bus.flush_bp_i     = fl;
    bus.lookup_valid_i = lv;
    bus.lookup_pc_i    = lpc;
    bus.upd_valid_i    = uv;
    bus.upd_pc_i       = upc;
    bus.upd_taken_i    = ut;
    li = lpc[7:1];
    ui = upc[7:1];
    ev = rst && !fl && lv && (m_left == 0);
    if (ev) q_exp.push_back(m_tab[li][1]);
    if (rst && !fl && uv && (m_left == 0)) begin
      if (ut) m_tab[ui] = (m_tab[ui] == 2'b11) ? 2'b11 : m_tab[ui] + 2'b01;
      else    m_tab[ui] = (m_tab[ui] == 2'b00) ? 2'b00 : m_tab[ui] - 2'b01;
    end
    @(posedge clk_i);
    #1;
    if (!rst || fl) begin
      m_left = 128;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        for (int i = 0; i < 128; i++) m_tab[i] = 2'b01;
      end
    end
    if (!rst) m_last = 1'b0;
    if (ev) m_last = q_exp.pop_front();

    n_vec++;
    assert (bus.busy_o === (m_left > 0)) else begin
      n_err++;
      $error("FAIL %s busy_o got=%b exp=%b", tag, bus.busy_o, (m_left > 0));
    end
    n_vec++;
    assert (bus.pred_valid_o === ev) else begin
      n_err++;
      $error("FAIL %s pred_valid_o got=%b exp=%b", tag, bus.pred_valid_o, ev);
    end
    n_vec++;
    assert (bus.pred_taken_o === m_last) else begin
      n_err++;
      $error("FAIL %s pred_taken_o got=%b exp=%b", tag, bus.pred_taken_o, m_last);
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input string tag);
    step(1'b1, 1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, tag);
  endtask

  task automatic update(input logic [31:0] pc, input bit t, input string tag);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, pc, t, tag);
  endtask

  // Sweep-time traffic: lookups and taken updates that must all be ignored.
  task automatic busy_traffic(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, PC_A, 1'b1, PC_A, 1'b1, tag);
  endtask

  // Drive every entry to strong-taken with back-to-back updates.
  task automatic train_all(input string tag);
    logic [31:0] pc;
    logic [31:0] prev;
    prev = 32'h8000_0000;
    for (int i = 0; i < 128; i++) begin
      pc = 32'h8000_0000 + 32'(i * 2);
      step(1'b1, 1'b0, 1'b1, prev, 1'b1, pc, 1'b1, tag);
      step(1'b1, 1'b0, 1'b1, pc,   1'b1, pc, 1'b1, tag);
      prev = pc;
    end
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 128; i++) lookup(32'h8000_0000 + 32'(i * 2), tag);
  endtask

  initial begin
    rst_ni             = 1'b0;
    bus.flush_bp_i     = 1'b0;
    bus.lookup_valid_i = 1'b0;
    bus.lookup_pc_i    = '0;
    bus.upd_valid_i    = 1'b0;
    bus.upd_pc_i       = '0;
    bus.upd_taken_i    = 1'b0;

    // Reset for two cycles, then the power-up sweep under ignored traffic.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset");
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "reset");
    busy_traffic(128, "sweep0");
    lookup(PC_A, "post_sweep");

    // Training and saturation at index 8.
    update(PC_A, 1'b1, "train_t");
    update(PC_A, 1'b1, "train_t");
    lookup(PC_A, "after_2t");
    update(PC_A, 1'b0, "train_nt");
    update(PC_A, 1'b0, "train_nt");
    update(PC_A, 1'b0, "train_nt");
    lookup(PC_A, "after_3nt");
    update(PC_A, 1'b0, "sat_low");
    lookup(PC_A, "sat_low");
    update(PC_A, 1'b1, "from_00");
    lookup(PC_A, "at_01");
    update(PC_A, 1'b1, "to_10");
    lookup(PC_A, "at_10");

    // Aliasing: index 8 to strong-taken, read via an aliased PC and a neighbour.
    update(PC_A, 1'b1, "to_11");
    lookup(PC_AL, "alias");
    lookup(PC_B, "neighbour");

    // Read-before-write at 01 (old says NT, new would say T).
    step(1'b1, 1'b0, 1'b1, PC_B, 1'b1, PC_B, 1'b1, "rbw_01");
    lookup(PC_B, "rbw_01_next");
    // Read-before-write at 10 going to 11.
    update(PC_A, 1'b0, "to_10b");
    step(1'b1, 1'b0, 1'b1, PC_A, 1'b1, PC_A, 1'b1, "rbw_10");
    lookup(PC_A, "rbw_10_next");
    update(PC_A, 1'b0, "check_11");
    lookup(PC_A, "check_11");
    update(PC_A, 1'b1, "back_11");

    // Flush with lookup and update in the same cycle, every entry strong-taken.
    train_all("train_all1");
    step(1'b1, 1'b1, 1'b1, PC_A, 1'b1, PC_A, 1'b1, "flush_mix");
    busy_traffic(127, "sweep1");
    read_all("clear1");

    // Flush mid-sweep, then reset mid-restarted-sweep.
    train_all("train_all2");
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "flush2");
    busy_traffic(49, "sweep2");
    step(1'b1, 1'b1, 1'b1, PC_A, 1'b1, PC_A, 1'b1, "flush_mid");
    busy_traffic(29, "sweep3");
    step(1'b0, 1'b0, 1'b1, PC_A, 1'b1, PC_A, 1'b1, "reset_mid");
    busy_traffic(128, "sweep4");
    read_all("clear2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
